alu_bist_sequencer: RTL

//  Synthesisable, parametrised self-checking sequencer for the ALU. Walks a vector ROM, drives the
//  ALU op and operands, and compares aluOut and the 5-bit conds against the expected values.

---
 rtl/alu_bist_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_bist_sequencer.sv
// rtl/alu_bist_sequencer.sv - ROM-driven ALU self-test sequencer with mismatch counting
// Start is registered once before the FSM sees it, so a run ends in cycle N*(3+ALU_LAT)+2.
module alu_bist_sequencer #(
    parameter int WIDTH   = 16,
    parameter int NUM_VEC = 64,
    parameter int ALU_LAT = 0,
    parameter int ERR_W   = 8,
    parameter int AW      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    parameter int VEC_W   = 3 * WIDTH + 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               loop_en,
    output logic [AW-1:0]      vec_addr,
    input  logic [VEC_W-1:0]   vec_data,
    output logic [7:0]         alu_op,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic [4:0]         alu_conds,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               fail_valid,
    output logic [AW-1:0]      first_fail_addr
);

    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [7:0]         op_q, op_d;
    logic [WIDTH-1:0]   in1_q, in1_d;
    logic [WIDTH-1:0]   in2_q, in2_d;
    logic [WIDTH-1:0]   exp_out_q, exp_out_d;
    logic [4:0]         exp_conds_q, exp_conds_d;
    logic               chk_out_q, chk_out_d;
    logic               chk_conds_q, chk_conds_d;
    logic [LW-1:0]      wait_q, wait_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fail_q, fail_d;
    logic [AW-1:0]      ffa_q, ffa_d;
    logic               mismatch;
    logic               last_vec;

    // Vector layout, MSB first: op, in1, in2, exp_out, exp_conds, chk_out, chk_conds
    logic [7:0]         v_op;
    logic [WIDTH-1:0]   v_in1, v_in2, v_exp;
    assign v_op  = vec_data[VEC_W-1 -: 8];
    assign v_in1 = vec_data[VEC_W-9 -: WIDTH];
    assign v_in2 = vec_data[VEC_W-9-WIDTH -: WIDTH];
    assign v_exp = vec_data[VEC_W-9-2*WIDTH -: WIDTH];

    assign last_vec = (idx_q == AW'(NUM_VEC - 1));

    always_comb begin
        state_d     = state_q;
        start_d     = start;
        idx_d       = idx_q;
        op_d        = op_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        exp_out_d   = exp_out_q;
        exp_conds_d = exp_conds_q;
        chk_out_d   = chk_out_q;
        chk_conds_d = chk_conds_q;
        wait_d      = wait_q;
        err_d       = err_q;
        fail_d      = fail_q;
        ffa_d       = ffa_q;
        mismatch    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_q) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = 1'b0;
                    ffa_d   = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                // A terminator is never applied, so the ALU inputs keep the last real vector
                if (v_op == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    op_d        = v_op;
                    in1_d       = v_in1;
                    in2_d       = v_in2;
                    exp_out_d   = v_exp;
                    exp_conds_d = vec_data[6:2];
                    chk_out_d   = vec_data[1];
                    chk_conds_d = vec_data[0];
                    wait_d      = '0;
                    state_d     = (ALU_LAT > 0) ? S_WAIT : S_CHECK;
                end
            end
            S_WAIT: begin
                if (wait_q == LW'(ALU_LAT - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHECK: begin
                mismatch = (chk_out_q && (alu_out != exp_out_q)) ||
                           (chk_conds_q && (alu_conds != exp_conds_q));
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_q) begin
                        fail_d = 1'b1;
                        ffa_d  = idx_q;
                    end
                end
                if (last_vec && loop_en) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end else if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            idx_q       <= '0;
            op_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            exp_out_q   <= '0;
            exp_conds_q <= '0;
            chk_out_q   <= 1'b0;
            chk_conds_q <= 1'b0;
            wait_q      <= '0;
            err_q       <= '0;
            fail_q      <= 1'b0;
            ffa_q       <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            exp_out_q   <= exp_out_d;
            exp_conds_q <= exp_conds_d;
            chk_out_q   <= chk_out_d;
            chk_conds_q <= chk_conds_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            ffa_q       <= ffa_d;
        end
    end

    assign vec_addr        = idx_q;
    assign alu_op          = op_q;
    assign alu_in1         = in1_q;
    assign alu_in2         = in2_q;
    assign busy            = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                             (state_q == S_WAIT)  || (state_q == S_CHECK);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign fail_valid      = fail_q;
    assign first_fail_addr = ffa_q;

endmodule
